// File: rtl/tohost_monitor.sv
// Purpose: tohost store responder; decodes riscv-tests pass/fail/test number and runs a watchdog.
// Latency: wr_ack and status outputs are registered, visible one cycle after the store is sampled.
// Backpressure: none; every store is accepted in the cycle it is presented, and wr_ack never stalls.
module tohost_monitor #(
  parameter logic [31:0] TOHOST_ADDR   = 32'h0000_1000,
  parameter int unsigned TIMEOUT_TICKS = 5000,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [31:0]      wr_addr,
  input  logic [31:0]      wr_data,
  input  logic [3:0]       wr_be,
  output logic             wr_ack,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             halt,
  output logic [30:0]      test_num,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [1:0] {
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TIMEOUT
  } state_t;

  // Counter value on the last RUN cycle before the watchdog fires.
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(TIMEOUT_TICKS - 1);

  state_t      state_q;
  state_t      state_d;
  logic [30:0] test_num_d;
  logic        hit;
  logic        capture;
  logic        is_pass;
  logic        is_fail;
  logic        expiry;

  // Byte offset within the word does not matter for the hit decision.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, wr_addr[1:0]};

  assign hit     = wr_en && (wr_addr[31:2] == TOHOST_ADDR[31:2]);
  // Only full-word stores while still running can decide the outcome.
  assign capture = hit && (state_q == S_RUN) && (wr_be == 4'hF);
  assign is_pass = capture && (wr_data == 32'h1);
  assign is_fail = capture && wr_data[0] && (wr_data != 32'h1);
  assign expiry  = (cycles == LAST_TICK);

  // Next-state decode: a deciding store beats watchdog expiry in the same cycle.
  always_comb begin
    state_d    = state_q;
    test_num_d = test_num;
    if (state_q == S_RUN) begin
      if (is_pass) begin
        state_d = S_PASS;
      end else if (is_fail) begin
        state_d    = S_FAIL;
        test_num_d = wr_data[31:1];
      end else if (expiry) begin
        state_d = S_TIMEOUT;
      end
    end
  end

  // State, captured test number and store acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_RUN;
      test_num <= '0;
      wr_ack   <= 1'b0;
    end else begin
      state_q  <= state_d;
      test_num <= test_num_d;
      wr_ack   <= hit;
    end
  end

  // Cycle counter: runs only in RUN, saturates at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycles <= '0;
    end else if ((state_q == S_RUN) && (cycles != '1)) begin
      cycles <= cycles + CNT_W'(1);
    end
  end

  assign pass    = (state_q == S_PASS);
  assign fail    = (state_q == S_FAIL);
  assign timeout = (state_q == S_TIMEOUT);
  assign done    = pass | fail | timeout;
  assign halt    = done;

endmodule

// File: tb/tb_tohost_monitor.sv
module tb_tohost_monitor;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;

  // Instance with the default watchdog (5000 ticks).
  logic        b_ack, b_done, b_pass, b_fail, b_timeout, b_halt;
  logic [30:0] b_tnum;
  logic [31:0] b_cycles;
  // Instance with a short watchdog (20 ticks), fed the same stores.
  logic        s_ack, s_done, s_pass, s_fail, s_timeout, s_halt;
  logic [30:0] s_tnum;
  logic [31:0] s_cycles;

  int n_cmp = 0;
  int n_err = 0;

  tohost_monitor u_big (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ack(b_ack), .done(b_done), .pass(b_pass), .fail(b_fail), .timeout(b_timeout),
    .halt(b_halt), .test_num(b_tnum), .cycles(b_cycles)
  );

  tohost_monitor #(.TIMEOUT_TICKS(20)) u_small (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
    .wr_ack(s_ack), .done(s_done), .pass(s_pass), .fail(s_fail), .timeout(s_timeout),
    .halt(s_halt), .test_num(s_tnum), .cycles(s_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge, ending at the following falling edge where outputs are sampled.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    wr_be   = be;
  endtask

  task automatic idle();
    wr_en   = 1'b0;
    wr_addr = 32'h0;
    wr_data = 32'h0;
    wr_be   = 4'h0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    #3;
    check("reset_ack",    {31'h0, b_ack},  32'h0);
    check("reset_done",   {31'h0, b_done}, 32'h0);
    check("reset_tnum",   {1'b0, b_tnum},  32'h0);
    check("reset_cycles", b_cycles,        32'h0);
    check("reset_s_done", {31'h0, s_done}, 32'h0);

    // ---- Timeout on the short-watchdog instance ----
    @(negedge clk);
    rst = 1'b1;
    tick(19);
    check("to_pre_timeout", {31'h0, s_timeout}, 32'h0);
    check("to_pre_cycles",  s_cycles,           32'd19);
    tick(1);
    check("to_timeout", {31'h0, s_timeout}, 32'h1);
    check("to_cycles",  s_cycles,           32'd20);
    check("to_pf",      {30'h0, s_pass, s_fail}, 32'h0);
    check("to_halt",    {30'h0, s_done, s_halt}, 32'h3);
    check("to_big_run", {31'h0, b_done},    32'h0);
    tick(3);
    check("to_frozen",  s_cycles,           32'd20);

    // ---- Ignored traffic on the default instance (now at edge 23) ----
    tick(6);
    store(32'h0000_1000, 32'h0000_0040, 4'hF);
    tick(1);
    check("ign_even_ack",  {31'h0, b_ack},  32'h1);
    check("ign_even_done", {31'h0, b_done}, 32'h0);
    check("ign_cycles",    b_cycles,        32'd30);
    store(32'h0000_1000, 32'h0000_0001, 4'h1);
    tick(1);
    check("ign_be_ack",  {31'h0, b_ack},  32'h1);
    check("ign_be_done", {31'h0, b_done}, 32'h0);
    store(32'h0000_1004, 32'h0000_0001, 4'hF);
    tick(1);
    check("ign_addr_ack",  {31'h0, b_ack},  32'h0);
    check("ign_addr_done", {31'h0, b_done}, 32'h0);
    store(32'h0000_1003, 32'h0000_0040, 4'hF);
    tick(1);
    check("ign_lsb_ack",  {31'h0, b_ack},  32'h1);
    check("ign_lsb_ack_to", {31'h0, s_ack}, 32'h1);
    idle();
    tick(1);
    check("ign_ack_drop", {31'h0, b_ack}, 32'h0);

    // ---- Pass path: store sampled on edge 101 ----
    tick(66);
    check("pass_pre_cycles", b_cycles, 32'd100);
    store(32'h0000_1000, 32'h0000_0001, 4'hF);
    tick(1);
    check("pass_ack",    {31'h0, b_ack},  32'h1);
    check("pass_pass",   {31'h0, b_pass}, 32'h1);
    check("pass_dh",     {30'h0, b_done, b_halt}, 32'h3);
    check("pass_ft",     {30'h0, b_fail, b_timeout}, 32'h0);
    check("pass_cycles", b_cycles, 32'd101);
    check("pass_s_sticky", {29'h0, s_pass, s_fail, s_timeout}, 32'h1);
    idle();
    tick(5);
    check("pass_frozen", b_cycles,        32'd101);
    check("pass_ack_lo", {31'h0, b_ack},  32'h0);
    check("pass_sticky", {31'h0, b_pass}, 32'h1);

    // ---- Fail path ----
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    store(32'h0000_1000, 32'h0000_0007, 4'hF);
    tick(1);
    check("fail_fail",   {31'h0, b_fail}, 32'h1);
    check("fail_pass",   {31'h0, b_pass}, 32'h0);
    check("fail_tnum",   {1'b0, b_tnum},  32'd3);
    check("fail_cycles", b_cycles,        32'd1);
    check("fail_s_tnum", {1'b0, s_tnum},  32'd3);
    store(32'h0000_1000, 32'h0000_0001, 4'hF);
    tick(1);
    check("post_ack",  {31'h0, b_ack},  32'h1);
    check("post_pass", {31'h0, b_pass}, 32'h0);
    check("post_fail", {31'h0, b_fail}, 32'h1);
    check("post_tnum", {1'b0, b_tnum},  32'd3);
    store(32'h0000_1000, 32'h0000_0009, 4'hF);

    // ---- Async reset mid-cycle while in FAIL with an ack pending ----
    @(posedge clk);
    #2;
    check("ar_ack_before", {31'h0, b_ack}, 32'h1);
    check("ar_tnum_kept",  {1'b0, b_tnum}, 32'd3);
    rst = 1'b0;
    #1;
    check("ar_ack",    {31'h0, b_ack},  32'h0);
    check("ar_status", {27'h0, b_done, b_pass, b_fail, b_timeout, b_halt}, 32'h0);
    check("ar_tnum",   {1'b0, b_tnum},  32'h0);
    check("ar_cycles", b_cycles,        32'h0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    tick(3);
    check("ar_recount", b_cycles, 32'd3);
    store(32'h0000_1000, 32'h0000_0001, 4'hF);
    tick(1);
    check("ar_pass",  {31'h0, b_pass}, 32'h1);
    check("ar_cyc2",  b_cycles,        32'd4);
    idle();

    // ---- Race: deciding store on the expiry cycle of the short instance ----
    rst = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b1;
    tick(19);
    check("race_pre", s_cycles, 32'd19);
    store(32'h0000_1000, 32'h0000_0001, 4'hF);
    tick(1);
    check("race_pass",    {31'h0, s_pass},    32'h1);
    check("race_timeout", {31'h0, s_timeout}, 32'h0);
    check("race_cycles",  s_cycles,           32'd20);

    // ---- Non-deciding store on the expiry cycle still times out ----
    rst = 1'b0;
    idle();
    #1;
    @(negedge clk);
    rst = 1'b1;
    tick(19);
    store(32'h0000_1000, 32'h0000_0040, 4'hF);
    tick(1);
    check("race_even_timeout", {31'h0, s_timeout}, 32'h1);
    check("race_even_ack",     {31'h0, s_ack},     32'h1);
    idle();
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
